// File: rtl/lower_driver_pkg.sv
// lower_driver_pkg: FSM state encoding and default beat count shared by the lower_driver slice
package lower_driver_pkg;
   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
   localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/lower_driver_ser.sv
// lower_driver_ser: beat counter, pattern shift registers and capture register
// LOWER_DRIVER_CHECK_EN builds the per-beat a|b compare feeding err; otherwise err is tied low
module lower_driver_ser
   import lower_driver_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             run,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             lower_out,
   output logic             ina,
   output logic             inb,
   output logic             last,
   output logic [WIDTH-1:0] data,
   output logic             err
);
   localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sa, sb;
   assign ina  = run & sa[0];
   assign inb  = run & sb[0];
   assign last = cnt == CW'(WIDTH - 1);
   // patterns shift right so bit 0 always carries beat cnt; cnt saturates at the last beat
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt  <= '0;
         sa   <= '0;
         sb   <= '0;
         data <= '0;
      end else if (load) begin
         cnt  <= '0;
         sa   <= a;
         sb   <= b;
         data <= '0;
      end else if (run) begin
         cnt       <= last ? cnt : cnt + 1'b1;
         sa        <= sa >> 1;
         sb        <= sb >> 1;
         data[cnt] <= lower_out;
      end
`ifdef LOWER_DRIVER_CHECK_EN
   always_ff @(posedge clk or posedge reset)
      if (reset)     err <= 1'b0;
      else if (load) err <= 1'b0;
      else if (run)  err <= err | (lower_out != (sa[0] | sb[0]));
`else
   assign err = 1'b0;
`endif
endmodule

// File: rtl/lower_driver.sv
// lower_driver: serialises req_a/req_b onto a 1-bit peer and returns its per-beat samples
// Optional macro LOWER_DRIVER_CHECK_EN enables the a|b compare behind rsp_err
module lower_driver
   import lower_driver_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             lower_ina,
   output logic             lower_inb,
   input  logic             lower_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err
);
   state_t state, nxt;
   logic   last;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= nxt;
   always_comb begin
      req_ready = state == IDLE;
      rsp_valid = state == DONE;
      nxt = state == IDLE  ? (req_valid ? DRIVE : IDLE) :
            state == DRIVE ? (last ? DONE : DRIVE) :
                             (rsp_ready ? IDLE : DONE);
   end
   lower_driver_ser #(.WIDTH(WIDTH)) u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (req_valid & req_ready),
      .run       (state == DRIVE),
      .a         (req_a),
      .b         (req_b),
      .lower_out (lower_out),
      .ina       (lower_ina),
      .inb       (lower_inb),
      .last      (last),
      .data      (rsp_data),
      .err       (rsp_err)
   );
endmodule

// File: tb/tb_lower_driver.sv
// tb_lower_driver: scoreboard bench for lower_driver (WIDTH=8 with OR/AND peer, plus a WIDTH=1 instance)
module tb_lower_driver;
   logic clk = 0, reset = 1;
   logic req_valid = 0, rsp_ready = 1, peer_and = 0;
   logic [7:0] req_a = 0, req_b = 0, rsp_data;
   logic req_ready, lower_ina, lower_inb, lower_out, rsp_valid, rsp_err;
   logic v1 = 0, a1 = 0, b1 = 0, r1 = 1, rdy1, ina1, inb1, out1, rv1, d1, err1;
   int errors = 0, checks = 0, cyc = 0;
   logic [8:0] q[$];
`ifdef LOWER_DRIVER_CHECK_EN
   localparam logic AND_ERR = 1'b1;
`else
   localparam logic AND_ERR = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign lower_out = peer_and ? (lower_ina & lower_inb) : (lower_ina | lower_inb);
   assign out1 = ina1 | inb1;

   lower_driver #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .lower_ina(lower_ina), .lower_inb(lower_inb),
      .lower_out(lower_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );
   lower_driver #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
      .req_a(a1), .req_b(b1), .lower_ina(ina1), .lower_inb(inb1),
      .lower_out(out1), .rsp_valid(rv1), .rsp_ready(r1),
      .rsp_data(d1), .rsp_err(err1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every response handshake pops the oldest expectation
   always @(negedge clk)
      if (!reset && rsp_valid && rsp_ready) begin
         if (q.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            logic [8:0] e;
            e = q.pop_front();
            chk("rsp_data", rsp_data, e[8:1]);
            chk("rsp_err", rsp_err, e[0]);
         end
      end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed, input logic ee);
      int n = 0;
      @(posedge clk); #1 req_valid = 1; req_a = a; req_b = b;
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      chk("accept", req_ready, 1);
      q.push_back({ed, ee});
      @(posedge clk); #1 req_valid = 0; req_a = ~a; req_b = ~b;
   endtask

   task automatic beats(input logic [7:0] a, input logic [7:0] b);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("beat_ina", lower_ina, a[k]);
         chk("beat_inb", lower_inb, b[k]);
         chk("drive_busy", {req_ready, rsp_valid}, 0);
      end
      @(negedge clk);
      chk("latency", rsp_valid, 1);
   endtask

   task automatic wait_idle;
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      chk("idle", {req_ready, rsp_valid, lower_ina, lower_inb}, 4'b1000);
   endtask

   initial begin
      int n, t1, t2;
      // reset state, with a request already waiting for the first edge after release
      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_pins", {lower_ina, lower_inb}, 0);
      chk("rst_rsp", {rsp_valid, rsp_err}, 0);
      chk("rst_data", rsp_data, 0);
      req_valid = 1; req_a = 8'hA5; req_b = 8'h0F;
      q.push_back({8'hAF, 1'b0});
      @(posedge clk); #1 reset = 0;
      @(posedge clk); #1 req_valid = 0; req_a = 8'h00; req_b = 8'hFF;
      beats(8'hA5, 8'h0F);
      wait_idle();
      // AND peer
      peer_and = 1;
      send(8'hA5, 8'h0F, 8'h05, AND_ERR);
      wait_idle();
      peer_and = 0;
      // response back-pressure
      @(posedge clk); #1 rsp_ready = 0;
      send(8'h3C, 8'hC3, 8'hFF, 1'b0);
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      chk("done_valid", rsp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 req_valid = (i == 2); req_a = 8'h01; req_b = 8'h00;
         @(negedge clk);
         chk("hold_data", rsp_data, 8'hFF);
         chk("hold_ready", {req_ready, rsp_valid}, 2'b01);
      end
      @(posedge clk); #1 req_valid = 0; rsp_ready = 1;
      @(negedge clk);
      @(negedge clk);
      chk("after_rsp", {req_ready, rsp_valid}, 2'b10);
      // reset in the middle of DRIVE
      send(8'h0F, 8'hF0, 8'hFF, 1'b0);
      repeat (3) @(posedge clk);
      #1 chk("pre_reset_ina", lower_ina, 1);
      reset = 1;
      #1;
      chk("abort_pins", {lower_ina, lower_inb}, 0);
      chk("abort_state", {req_ready, rsp_valid}, 2'b10);
      q.delete();
      @(posedge clk); #1 reset = 0;
      chk("abort_data", rsp_data, 0);
      send(8'h01, 8'h00, 8'h01, 1'b0);
      beats(8'h01, 8'h00);
      wait_idle();
      // back-to-back with req_valid held high
      @(posedge clk); #1 req_valid = 1; req_a = 8'hA5; req_b = 8'h0F;
      q.push_back({8'hAF, 1'b0});
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      t1 = cyc;
      @(posedge clk); #1 req_a = 8'h3C; req_b = 8'hC3;
      q.push_back({8'hFF, 1'b0});
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      t2 = cyc;
      @(posedge clk); #1 req_valid = 0;
      chk("initiation_interval", t2 - t1, 10);
      wait_idle();
      // WIDTH = 1
      @(posedge clk); #1 v1 = 1; a1 = 1; b1 = 0;
      @(negedge clk); chk("w1_ready", rdy1, 1);
      @(posedge clk); #1 v1 = 0; a1 = 0;
      @(negedge clk); chk("w1_drive", {ina1, inb1, rv1}, 3'b100);
      @(negedge clk); chk("w1_done", {rv1, d1, err1}, 3'b110);
      @(negedge clk); chk("w1_idle", {rdy1, rv1}, 2'b10);
      repeat (2) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
